// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StFault} fetch_state_e;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  // Word-aligned and inside 0..limit-4.
  function automatic logic pc_legal(input logic [31:0] addr, input logic [31:0] limit);
    return (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// IF/ID output register backed by a one-entry skid so a response that lands
// while decode stalls is kept rather than dropped.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] ResetPc = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  fetch_entry_t in_entry_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output fetch_entry_t out_entry_o,
  input  logic         out_ready_i
);

  logic         out_valid_q, out_valid_d;
  fetch_entry_t out_entry_q, out_entry_d;
  logic         skid_valid_q, skid_valid_d;
  fetch_entry_t skid_entry_q, skid_entry_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_entry_d  = out_entry_q;
    skid_valid_d = skid_valid_q;
    skid_entry_d = skid_entry_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready_i) begin
      // Output frees up: older skid entry goes first, new response backfills the skid.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_entry_d  = skid_entry_q;
        skid_valid_d = in_valid_i;
        skid_entry_d = in_entry_i;
      end else begin
        out_valid_d = in_valid_i;
        if (in_valid_i) begin
          out_entry_d = in_entry_i;
        end
      end
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_entry_d = in_entry_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_entry_q  <= '{instr: '0, pc: ResetPc};
      skid_valid_q <= 1'b0;
      skid_entry_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_entry_q  <= out_entry_d;
      skid_valid_q <= skid_valid_d;
      skid_entry_q <= skid_entry_d;
    end
  end

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_entry_o = out_entry_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues imem reads from pc, computes next_pc (step/hold/redirect)
// and presents fetched words on a valid/ready IF/ID interface.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] ImemLimit = 32'(IMEM_BYTES);

  fetch_state_e state_q, state_d;
  logic         inflight_q;
  logic [31:0]  inflight_pc_q;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic         pc_ok, can_issue, issue, fault_evt;
  logic         skid_ready, resp_valid;
  fetch_entry_t resp_entry, out_entry;

  assign pc_ok = pc_legal(pc, ImemLimit);

  // A response still in flight while the output is stalled will occupy the skid,
  // so a second request could not be absorbed.
  assign can_issue = (state_q == StRun) && !redirect_valid && skid_ready &&
                     !(if_valid && !if_ready && inflight_q);
  assign issue     = can_issue && pc_ok;
  assign fault_evt = can_issue && !pc_ok;

  assign imem_en   = issue;
  assign imem_addr = pc;

  always_comb begin
    if (redirect_valid) begin
      next_pc = redirect_target;
    end else if (issue) begin
      next_pc = pc + 32'(PC_STEP);
    end else begin
      next_pc = pc;
    end
  end

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    unique case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        if (fault_evt) begin
          state_d    = StFault;
          fault_d    = 1'b1;
          fault_pc_d = pc;
        end
      end
      StFault: begin
        if (redirect_valid && pc_legal(redirect_target, ImemLimit)) begin
          state_d = StRun;
          fault_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc;
      end
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // A redirect in the response cycle kills the in-flight word.
  assign resp_valid = inflight_q && !redirect_valid;
  assign resp_entry = '{instr: imem_rdata, pc: inflight_pc_q};

  fetch_skid_buffer #(
    .ResetPc(RESET_PC)
  ) u_skid (
    .clk_i      (clk),
    .rst_ni     (rst),
    .flush_i    (redirect_valid),
    .in_valid_i (resp_valid),
    .in_entry_i (resp_entry),
    .in_ready_o (skid_ready),
    .out_valid_o(if_valid),
    .out_entry_o(out_entry),
    .out_ready_i(if_ready)
  );

  assign if_instr    = out_entry.instr;
  assign if_pc       = out_entry.pc;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;

endmodule
